cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined CPU. It sits between the caches/datapath memory interface and the RAM model, and grants exactly one requester at a time. A grant is held until the RAM reports completion, so address and data on the RAM port stay stable for the whole access. Data requests normally win, but a bounded-starvation counter guarantees that instruction fetch makes forward progress.

## Interface
Parameters:
- STARVE_MAX, default 4: maximum number of consecutive data completions that may occur while an instruction request is pending before instruction fetch is forced a grant.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data to write.
- iwait  out  1  0 only in the cycle the instruction access completes.
- dwait  out  1  0 only in the cycle the data access completes.
- iload  out  32  instruction read data; valid when iwait=0.
- dload  out  32  data read data; valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- FSM states: IDLE, IGNT, DGNT. All RAM outputs are driven combinationally from the registered state.
- IDLE:
  - RAM outputs are 0.
  - Next state is DGNT if (dREN|dWEN) and not starve; else IGNT if iREN; else IDLE.
  - starve = iREN && (dstreak == STARVE_MAX). When starve is true and iREN is asserted, the next state is IGNT even if a data request is pending.
- IGNT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - On ACCESS: iwait=0, iload=ramload, dstreak cleared to 0, next state IDLE.
- DGNT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. If both dREN and dWEN are asserted, the access is treated as a write.
  - On ACCESS: dwait=0, dload=ramload (reads only; 0 for writes), next state IDLE.
  - On ACCESS, if iREN=1, dstreak increments, saturating at STARVE_MAX.
- ERROR in either grant state:
  - Wait stays 1 and the state returns to IDLE.
  - The requester is re-arbitrated on the following cycle (retry).
- Request withdrawn while granted (e.g. the hazard unit flushes the fetch, so iREN=0 in IGNT):
  - RAM enables drop to 0 combinationally in that cycle and the state returns to IDLE.
  - No completion is signalled and dstreak is unchanged.
- FREE or BUSY in a grant state: hold the state; all outputs unchanged.
- The wait for the requester that is not granted is always 1. In IDLE, iwait=dwait=1.
- iload and dload are 0 whenever their wait is 1.
- dstreak is a register of width $clog2(STARVE_MAX+1).

## Timing
- Reset (asynchronous, nRST=0):
  - state=IDLE, dstreak=0.
  - iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset asserted mid-access: RAM enables drop immediately and no completion is signalled.
- Arbitration overhead is one cycle (IDLE). A request first sampled in cycle n drives the RAM in cycle n+1.
- Completion is signalled in the same cycle that ramstate==ACCESS. The state is back in IDLE at the next edge, and the earliest next grant drives the RAM at n+3 relative to a zero-latency access.
- A back-to-back requester therefore sees at least a 2-cycle gap between its completions.
- Requesters must hold address, data and enables stable while their wait is 1.
- iwait and dwait are never 0 in the same cycle.

## Test plan
- Reset: hold nRST=0 with all requests high -> iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0. Release -> first grant is DGNT.
- Lone fetch: iREN=1, iaddr=0x40, RAM answers ACCESS on its 2nd BUSY cycle with ramload=0x2108000A -> ramaddr=0x40 during the grant, iwait=0 and iload=0x2108000A for exactly one cycle, then IDLE.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> the data write is served first (ramWEN=1, ramstore=0xDEADBEEF), then the fetch; dstreak=1 after the write.
- Starvation: dREN held continuously with iREN held, STARVE_MAX=4 -> exactly 4 data completions, then an IGNT grant, and dstreak returns to 0.
- Withdrawal and error: drop iREN mid-IGNT -> ramREN=0 the same cycle and no iwait=0 pulse. Separately, ramstate=ERROR in DGNT -> dwait stays 1, IDLE, re-grant DGNT, and completion on the retry.
- Async reset mid-DGNT while BUSY -> outputs reach reset values without a clock edge; no completion pulse appears after release.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single RAM port between instruction fetch and data
// requesters. Data wins by default; a starvation counter forces a fetch grant.
module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   dstreak_r, dstreak_s;
  logic            dreq_s;
  logic            starve_s;

  assign dreq_s   = dREN | dWEN;
  assign starve_s = iREN & (dstreak_r == STREAK_MAX);

  // State and starvation counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      dstreak_r <= {SW{1'b0}};
    end else begin
      state_r   <= state_s;
      dstreak_r <= dstreak_s;
    end
  end

  // Arbitration, RAM port muxing and completion signalling
  always_comb begin
    state_s   = state_r;
    dstreak_s = dstreak_r;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = 32'h0;
    dload     = 32'h0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'h0;
    ramstore  = 32'h0;
    case (state_r)
      IDLE: begin
        if (dreq_s && !starve_s) begin
          state_s = DGNT;
        end else if (iREN) begin
          state_s = IGNT;
        end else begin
          state_s = IDLE;
        end
      end
      IGNT: begin
        // A withdrawn fetch (pipeline flush) releases the port without completing
        if (!iREN) begin
          state_s = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            iwait     = 1'b0;
            iload     = ramload;
            dstreak_s = {SW{1'b0}};
            state_s   = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            state_s = IDLE;
          end else begin
            state_s = IGNT;
          end
        end
      end
      DGNT: begin
        if (!dreq_s) begin
          state_s = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            dload   = dWEN ? 32'h0 : ramload;
            state_s = IDLE;
            if (iREN && (dstreak_r != STREAK_MAX)) begin
              dstreak_s = dstreak_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
              dstreak_s = dstreak_r;
            end
          end else if (ramstate == RAM_ERROR) begin
            state_s = IDLE;
          end else begin
            state_s = DGNT;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_cache_mem_arbiter;
  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  logic [131:0] obs_v, seen_v, exp_v, reset_v;
  int tests = 0;
  int fails = 0;
  int owner;   // 0 nobody, 1 fetch holds the port, 2 data holds the port
  int streak;  // data completions while a fetch was waiting

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  assign obs_v = {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore};

  function automatic logic [131:0] model_out();
    logic iw, dw, re, we;
    logic [31:0] il, dl, a, s;
    iw = 1'b1; dw = 1'b1; re = 1'b0; we = 1'b0;
    il = 32'h0; dl = 32'h0; a = 32'h0; s = 32'h0;
    if (nRST && owner == 1 && iREN) begin
      re = 1'b1; a = iaddr;
      if (ramstate == 2'd2) begin iw = 1'b0; il = ramload; end
    end
    if (nRST && owner == 2 && (dREN || dWEN)) begin
      we = dWEN; re = dREN && !dWEN; a = daddr; s = dstore;
      if (ramstate == 2'd2) begin dw = 1'b0; dl = dWEN ? 32'h0 : ramload; end
    end
    return {iw, dw, il, dl, re, we, a, s};
  endfunction

  task automatic model_update();
    bit dreq;
    dreq = dREN || dWEN;
    case (owner)
      0: if (dreq && !(iREN && streak == SMAX)) owner = 2; else if (iREN) owner = 1;
      1: if (!iREN || ramstate == 2'd3) owner = 0;
         else if (ramstate == 2'd2) begin streak = 0; owner = 0; end
      2: if (!dreq || ramstate == 2'd3) owner = 0;
         else if (ramstate == 2'd2) begin
           if (iREN && streak < SMAX) streak++;
           owner = 0;
         end
      default: owner = 0;
    endcase
  endtask

  task automatic check(input string tag, input logic [131:0] o, input logic [131:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
    check(tag, {100'h0, o}, {100'h0, e});
  endtask

  task automatic step(input string tag);
    @(negedge CLK);
    seen_v = obs_v;
    exp_v  = model_out();
    check(tag, seen_v, exp_v);
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    nRST = 1'b0;
    #2;
    check("reset", obs_v, reset_v);
    owner = 0; streak = 0;
    nRST = 1'b1;
  endtask

  initial begin
    int dcount, k, r;
    bit got;
    reset_v = {1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    owner = 0; streak = 0;

    // reset with every request high, then first grant must go to data
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h20; daddr = 32'h100; dstore = 32'h55; ramload = 32'h0; ramstate = 2'd0;
    @(posedge CLK); #1;
    check("reset_hold", obs_v, reset_v);
    nRST = 1'b1;
    step("rst_idle");
    ramstate = 2'd1;
    step("rst_grant");
    check32("first_dgnt_addr", seen_v[63:32], 32'h100);
    check32("first_dgnt_wen", {31'h0, seen_v[64]}, 32'h1);
    ramstate = 2'd2;
    step("rst_done");
    check32("first_dgnt_dwait", {31'h0, seen_v[130]}, 32'h0);

    // lone fetch
    do_reset();
    iREN = 1'b1; iaddr = 32'h40;
    step("f_idle");
    ramstate = 2'd1;
    step("f_busy");
    check32("fetch_addr", seen_v[63:32], 32'h40);
    ramstate = 2'd2; ramload = 32'h2108000A;
    step("f_acc");
    check32("fetch_iwait", {31'h0, seen_v[131]}, 32'h0);
    check32("fetch_iload", seen_v[129:98], 32'h2108000A);
    iREN = 1'b0; ramstate = 2'd0;
    step("f_after");
    check32("fetch_after_iwait", {31'h0, seen_v[131]}, 32'h1);

    // simultaneous: write first, then fetch
    do_reset();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    ramstate = 2'd2; ramload = 32'h12345678;
    step("s_idle");
    step("s_write");
    check32("sim_wen", {31'h0, seen_v[64]}, 32'h1);
    check32("sim_store", seen_v[31:0], 32'hDEADBEEF);
    check32("sim_dload", seen_v[97:66], 32'h0);
    dWEN = 1'b0;
    step("s_idle2");
    step("s_fetch");
    check32("sim_fetch_iwait", {31'h0, seen_v[131]}, 32'h0);
    check32("sim_fetch_addr", seen_v[63:32], 32'h44);

    // starvation: two rounds of exactly SMAX data completions before a fetch
    do_reset();
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; ramstate = 2'd2;
    for (int rnd = 0; rnd < 2; rnd++) begin
      dcount = 0; got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        step("starve");
        if (!seen_v[130]) dcount++;
        if (!seen_v[131]) got = 1'b1;
      end
      check32("starve_fetch_seen", {31'h0, got}, 32'h1);
      check32("starve_data_count", dcount, SMAX);
    end

    // fetch withdrawn while granted
    do_reset();
    iREN = 1'b1; iaddr = 32'h60; ramstate = 2'd1;
    step("w_idle");
    step("w_ignt");
    check32("wd_ren_before", {31'h0, seen_v[65]}, 32'h1);
    iREN = 1'b0; #1;
    check32("wd_ren_drop", {31'h0, ramREN}, 32'h0);
    ramstate = 2'd2;
    step("w_nocomp");
    step("w_idle2");

    // RAM error then retry
    do_reset();
    dREN = 1'b1; daddr = 32'h90; ramstate = 2'd3;
    step("e_idle");
    step("e_err");
    check32("err_dwait", {31'h0, seen_v[130]}, 32'h1);
    step("e_back");
    ramstate = 2'd2; ramload = 32'hCAFEF00D;
    step("e_retry");
    check32("retry_dwait", {31'h0, seen_v[130]}, 32'h0);
    check32("retry_dload", seen_v[97:66], 32'hCAFEF00D);

    // async reset mid-data-grant
    do_reset();
    dREN = 1'b1; daddr = 32'hA0; ramstate = 2'd1;
    step("a_idle");
    step("a_dgnt");
    #2; nRST = 1'b0; #1;
    check("async_reset", obs_v, reset_v);
    @(posedge CLK); #1;
    nRST = 1'b1; owner = 0; streak = 0;
    dREN = 1'b0; ramstate = 2'd2;
    for (int c = 0; c < 3; c++) step("a_after");

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!iREN || !exp_v[131]) begin
        iREN = ($urandom_range(0, 1) == 1);
        iaddr = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        iREN = 1'b0;
      end
      if (!(dREN || dWEN) || !exp_v[130]) begin
        k = $urandom_range(0, 3);
        dREN = (k & 1) != 0; dWEN = (k & 2) != 0;
        daddr = $urandom; dstore = $urandom;
      end
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? 2'd1 : (r == 4) ? 2'd0 : (r < 9) ? 2'd2 : 2'd3;
      ramload = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
